// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 frame receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - pin synchronizers and registered PS/2 clock falling-edge detect
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fe
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic prev_clk_q, prev_clk_d;
    logic fe_q, fe_d;
    logic data_s_q, data_s_d;
    logic clk_s;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    // data gets one extra stage so it lines up with the registered edge pulse
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        prev_clk_d  = clk_s;
        fe_d        = prev_clk_q & ~clk_s;
        data_s_d    = data_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            prev_clk_q  <= 1'b1;
            fe_q        <= 1'b0;
            data_s_q    <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            prev_clk_q  <= prev_clk_d;
            fe_q        <= fe_d;
            data_s_q    <= data_s_d;
        end
    end

    assign fe     = fe_q;
    assign data_s = data_s_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 11-bit frame receiver folding E0/F0 prefixes into scancode events
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2956
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       break_o,
    output logic       ext_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic data_s, fe;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data_s  (data_s),
        .fe      (fe)
    );

    ps2_rx_state_t state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_q, par_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          ext_pend_q, ext_pend_d;
    logic          brk_pend_q, brk_pend_d;
    logic [7:0]    code_q, code_d;
    logic          break_q, break_d;
    logic          ext_q, ext_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        par_d      = par_q;
        tmo_d      = '0;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        code_d     = code_q;
        break_d    = break_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!(odd_parity_ok(shift_q, par_q) && data_s)) begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end else if (shift_q == PS2_EXT_PREFIX) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == PS2_BREAK_PREFIX) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        code_d     = shift_q;
                        break_d    = brk_pend_q;
                        ext_d      = ext_pend_q;
                        valid_d    = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // an edge in the same cycle always takes priority over the timeout
            if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d    = IDLE;
                err_d      = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                tmo_d = tmo_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            code_q     <= 8'h00;
            break_q    <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            code_q     <= code_d;
            break_q    <= break_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign code_o  = code_q;
    assign break_o = break_q;
    assign ext_o   = ext_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard bench for ps2_frame_rx
module tb_ps2_frame_rx;

    localparam int TMO = 2956;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    logic       clk_i = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code_o;
    logic       break_o, ext_o, valid_o, err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int err_cyc = -1;
    ev_t exp_q[$];

    ps2_frame_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .code_o  (code_o),
        .break_o (break_o),
        .ext_o   (ext_o),
        .valid_o (valid_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        #100;
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        #200;
        ps2_clk = 1'b1;
        #100;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ par_flip);
        send_bit(stop_bit);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk_i);
    endtask

    function automatic ev_t ok_ev(input logic [7:0] c, input logic brk, input logic ext);
        return '{is_err: 1'b0, code: c, brk: brk, ext: ext};
    endfunction

    localparam ev_t ERR_EV = '{is_err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0};

    // monitor: pops one expectation per output event
    initial begin
        ev_t act, req;
        forever begin
            @(negedge clk_i);
            if (reset_n && (valid_o || err_o)) begin
                if (valid_o && err_o) check("valid_and_err_together", 1, 0);
                if (err_o) begin
                    err_cyc = cyc;
                    act = ERR_EV;
                end else begin
                    act = ok_ev(code_o, break_o, ext_o);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {20'd0, act}, 32'hFFFFFFFF);
                end else begin
                    req = exp_q.pop_front();
                    check("event", {20'd0, act}, {20'd0, req});
                end
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_code", code_o, 8'h00);
        check("rst_break", break_o, 0);
        check("rst_ext", ext_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_err", err_o, 0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk_i);

        exp_q.push_back(ok_ev(8'h1C, 1'b0, 1'b0));
        send_frame(8'h1C, 1'b0, 1'b1);

        exp_q.push_back(ok_ev(8'h1C, 1'b1, 1'b0));
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);

        exp_q.push_back(ok_ev(8'h75, 1'b1, 1'b1));
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);

        exp_q.push_back(ok_ev(8'h75, 1'b0, 1'b0));
        send_frame(8'h75, 1'b0, 1'b1);

        exp_q.push_back(ERR_EV);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("code_hold_after_parity_err", code_o, 8'h75);

        exp_q.push_back(ERR_EV);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("code_hold_after_stop_err", code_o, 8'h75);

        exp_q.push_back(ERR_EV);
        err_cyc = -1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 40) @(posedge clk_i);
        check("timeout_err_seen", err_cyc >= 0, 1);
        check("timeout_window", (err_cyc >= last_fall_cyc + TMO) && (err_cyc <= last_fall_cyc + TMO + 8), 1);

        exp_q.push_back(ok_ev(8'h29, 1'b0, 1'b0));
        send_frame(8'h29, 1'b0, 1'b1);

        send_frame(8'hF0, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        @(negedge clk_i);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_i);
        check("midrst_code", code_o, 8'h00);
        check("midrst_valid_err", {valid_o, err_o}, 2'b00);
        reset_n = 1'b1;
        repeat (10) @(posedge clk_i);
        exp_q.push_back(ok_ev(8'h1C, 1'b0, 1'b0));
        send_frame(8'h1C, 1'b0, 1'b1);

        repeat (50) @(posedge clk_i);
        check("pending_expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
